mips_cpu_alu_hilo: RTL and testbench
====================================

# mips_cpu_alu_hilo

Execution unit that consumes the 5-bit `alucontrol` code produced by the controller's ALU decoder in the bus-based multicycle MIPS CPU. It computes single-cycle results combinationally and evaluates branch conditions. It runs MULT/MULTU/DIV/DIVU iteratively and owns the architectural HI/LO registers. The controller holds the EXEC state while `busy` is high.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low; sampled on rising edge of `clk`.
- `start` in 1: one-cycle strobe, EXEC state; launches mul/div or MTHI/MTLO write.
- `alucontrol` in 5: operation code (encoding below).
- `a` in 32: srcA (rs).
- `b` in 32: srcB (rt or extended immediate).
- `shamt` in 5: instruction shift-amount field.
- `result` out 32: combinational result.
- `zero` out 1: `result == 0`.
- `cond` out 1: branch condition true.
- `busy` out 1: mul/div in progress.
- `done` out 1: one-cycle pulse on mul/div completion.
- `hi`, `lo` out 32 each: architectural HI/LO.

## Operation
- Codes and `result`:
  - 00000 AND, 00001 OR, 00010 XOR.
  - 00011 ADDU (`a+b` mod 2^32). 00100 SUBU (`a-b` mod 2^32).
  - 00101 SLTU, 00110 SLT: result 1/0, signed compare for SLT.
  - 01001 SLL, 01100 SRL, 01011 SRA: shift `b` by `shamt`.
  - 01010 SLLV, 01110 SRLV, 01101 SRAV: shift `b` by `a[4:0]`.
  - 11001 LUI: `{b[15:0],16'h0}`.
  - 11000 PASS: `a`, used for JR/JALR/jumps.
  - 11010 MFHI: `hi`. 11011 MFLO: `lo`.
- Branch codes, `result` = `a`:
  - 10011: `cond = a<0`.
  - 10100: `cond = a>0`.
  - 10101: `cond = a>=0`.
  - 10110: `cond = a!=b`.
  - 10111: `cond = a<=0`.
  - BEQ uses SUBU plus `zero`.
  - `cond`=0 for every non-branch code.
- Codes 00111 MULTU, 01000 MULT, 01111 DIV, 10000 DIVU, 10001 MTHI, 10010 MTLO: `result` = 0.
- Undefined codes 11100–11111: `result`=0, `cond`=0, no state change.
- MTHI/MTLO: `start` while idle writes `a` to HI/LO at that edge.
- Mul/div FSM, states IDLE → RUN → FIN → IDLE:
  - IDLE + `start` + mul/div code: latch operands into RUN. For signed ops, latch magnitudes and the result signs.
  - RUN: 32 iterations, one per edge. Multiply is shift-add into a 64-bit accumulator. Divide is restoring, one quotient bit per edge.
  - FIN: apply sign correction, write HI/LO, pulse `done`, return to IDLE.
- Arithmetic rules:
  - MULT/MULTU: `{HI,LO}` = full 64-bit product.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Signed divide truncates toward zero; remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0: the iteration still runs and `done` still pulses; HI/LO left unchanged.
- `start` while `busy`: ignored, including MTHI/MTLO.
- MFHI/MFLO while `busy`: return the old HI/LO.

## Timing
- Reset (`reset`=0 at an edge):
  - `busy`=0, `done`=0, `hi`=0, `lo`=0, FSM=IDLE.
  - Any in-flight op is aborted; HI/LO are not written.
- `result`, `zero`, `cond` are combinational from inputs and HI/LO. After reset: MFHI/MFLO read 0.
- Mul/div latency, with edge E0 sampling `start`:
  - `busy`=1 after E0 through E32.
  - E33 writes HI/LO; `busy`=0 and `done`=1 during the cycle after E33.
  - `done`=0 after E34.
  - `start` to visible HI/LO = 33 cycles.
- A new `start` is accepted on the same edge at which `done` is high, since the FSM is IDLE then.
- MTHI/MTLO: HI/LO visible the cycle after the `start` edge.

## Test plan
- ADDU 0xFFFFFFFF + 0x00000001 → `result`=0, `zero`=1. SLT 0xFFFFFFFF vs 1 → 1. SLTU → 0.
- SRA `b`=0x80000000, `shamt`=4 → 0xF8000000. SRLV `a`=36, `b`=0x80000000 → 0x08000000 (uses a[4:0]=4). LUI `b`=0x1234 → 0x12340000.
- Branch conditions:
  - Code 10101, `a`=0 → `cond`=1.
  - Code 10100, `a`=0 → `cond`=0.
  - Code 10110, `a`=`b`=5 → `cond`=0.
  - Code 00011 → `cond`=0.
- MULT `a`=-3, `b`=5:
  - `busy` high exactly 33 cycles; `done` one cycle.
  - HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - MULTU 0xFFFFFFFF² → HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7 / 0 → HI/LO unchanged, `done` still pulses.
- Second `start` mid-run is ignored.
- `reset` low at cycle 10 of DIVU → `busy`=0, HI=LO=0 next cycle, no `done`.
- MTHI 0xDEADBEEF, then MFHI → 0xDEADBEEF next cycle.

Source files
------------

// File: rtl/mips_cpu_alu_hilo.sv
// Execution unit for the bus-based multicycle MIPS CPU.
// Single-cycle ALU operations and branch conditions are combinational. MULT/MULTU/DIV/DIVU
// run iteratively over 32 clock edges, and this block owns the architectural HI/LO registers.
// The controller holds its EXEC state while busy is high.
module mips_cpu_alu_hilo (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  alucontrol,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic [31:0] result,
    output logic        zero,
    output logic        cond,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Operation codes produced by the controller's ALU decoder
    localparam logic [4:0] OP_AND   = 5'b00000;
    localparam logic [4:0] OP_OR    = 5'b00001;
    localparam logic [4:0] OP_XOR   = 5'b00010;
    localparam logic [4:0] OP_ADDU  = 5'b00011;
    localparam logic [4:0] OP_SUBU  = 5'b00100;
    localparam logic [4:0] OP_SLTU  = 5'b00101;
    localparam logic [4:0] OP_SLT   = 5'b00110;
    localparam logic [4:0] OP_MULTU = 5'b00111;
    localparam logic [4:0] OP_MULT  = 5'b01000;
    localparam logic [4:0] OP_SLL   = 5'b01001;
    localparam logic [4:0] OP_SLLV  = 5'b01010;
    localparam logic [4:0] OP_SRA   = 5'b01011;
    localparam logic [4:0] OP_SRL   = 5'b01100;
    localparam logic [4:0] OP_SRAV  = 5'b01101;
    localparam logic [4:0] OP_SRLV  = 5'b01110;
    localparam logic [4:0] OP_DIV   = 5'b01111;
    localparam logic [4:0] OP_DIVU  = 5'b10000;
    localparam logic [4:0] OP_MTHI  = 5'b10001;
    localparam logic [4:0] OP_MTLO  = 5'b10010;
    localparam logic [4:0] OP_BLTZ  = 5'b10011;
    localparam logic [4:0] OP_BGTZ  = 5'b10100;
    localparam logic [4:0] OP_BGEZ  = 5'b10101;
    localparam logic [4:0] OP_BNE   = 5'b10110;
    localparam logic [4:0] OP_BLEZ  = 5'b10111;
    localparam logic [4:0] OP_PASS  = 5'b11000;
    localparam logic [4:0] OP_LUI   = 5'b11001;
    localparam logic [4:0] OP_MFHI  = 5'b11010;
    localparam logic [4:0] OP_MFLO  = 5'b11011;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [63:0] acc;       // multiply: running product; divide: {remainder, quotient/dividend}
    logic [31:0] opd;       // multiplicand or divisor magnitude
    logic        isdiv;
    logic        negq;      // negate product / quotient at the end
    logic        negr;      // negate remainder at the end (sign of dividend)
    logic        divzero;

    // Decode of the launch request and operand magnitudes for signed ops
    logic        ismuldiv;
    logic        issigned;
    logic [31:0] amag;
    logic [31:0] bmag;

    assign ismuldiv = (alucontrol == OP_MULTU) || (alucontrol == OP_MULT) ||
                      (alucontrol == OP_DIV)   || (alucontrol == OP_DIVU);
    assign issigned = (alucontrol == OP_MULT) || (alucontrol == OP_DIV);
    assign amag     = (issigned && a[31]) ? (32'd0 - a) : a;
    assign bmag     = (issigned && b[31]) ? (32'd0 - b) : b;

    // One shift-add multiply step: conditionally add multiplicand to the upper half, shift right
    logic [32:0] mulsum;
    logic [63:0] mulnext;

    assign mulsum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opd} : 33'd0);
    assign mulnext = {mulsum, acc[31:1]};

    // One restoring divide step: shift in next dividend bit, subtract divisor if it fits
    logic [32:0] divtrial;
    logic        divfits;
    logic [31:0] divdiff;
    logic [63:0] divnext;

    assign divtrial = {acc[63:32], acc[31]};
    assign divfits  = (divtrial >= {1'b0, opd});
    assign divdiff  = divtrial[31:0] - opd;
    assign divnext  = divfits ? {divdiff, acc[30:0], 1'b1}
                              : {divtrial[31:0], acc[30:0], 1'b0};

    // Sign correction applied when the iteration finishes
    logic [63:0] prodfinal;
    logic [31:0] quotfinal;
    logic [31:0] remfinal;

    assign prodfinal = negq ? (64'd0 - acc) : acc;
    assign quotfinal = negq ? (32'd0 - acc[31:0]) : acc[31:0];
    assign remfinal  = negr ? (32'd0 - acc[63:32]) : acc[63:32];

    // Mul/div sequencer and HI/LO ownership, including MTHI/MTLO writes when idle
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            acc     <= 64'd0;
            opd     <= 32'd0;
            isdiv   <= 1'b0;
            negq    <= 1'b0;
            negr    <= 1'b0;
            divzero <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (ismuldiv) begin
                            acc     <= {32'd0, amag};
                            opd     <= bmag;
                            isdiv   <= (alucontrol == OP_DIV) || (alucontrol == OP_DIVU);
                            negq    <= issigned && (a[31] ^ b[31]);
                            negr    <= issigned && a[31];
                            divzero <= (b == 32'd0);
                            cnt     <= 5'd0;
                            busy    <= 1'b1;
                            state   <= RUN;
                        end else if (alucontrol == OP_MTHI) begin
                            hi <= a;
                        end else if (alucontrol == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                RUN: begin
                    acc <= isdiv ? divnext : mulnext;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    if (!isdiv) begin
                        hi <= prodfinal[63:32];
                        lo <= prodfinal[31:0];
                    end else if (!divzero) begin
                        hi <= remfinal;
                        lo <= quotfinal;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Combinational result selection for every ALU code; mul/div/move-to and undefined codes give 0
    always_comb begin
        result = 32'd0;
        case (alucontrol)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_ADDU: result = a + b;
            OP_SUBU: result = a - b;
            OP_SLTU: result = {31'd0, (a < b)};
            OP_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
            OP_SLL:  result = b << shamt;
            OP_SRL:  result = b >> shamt;
            OP_SRA:  result = $unsigned($signed(b) >>> shamt);
            OP_SLLV: result = b << a[4:0];
            OP_SRLV: result = b >> a[4:0];
            OP_SRAV: result = $unsigned($signed(b) >>> a[4:0]);
            OP_LUI:  result = {b[15:0], 16'h0000};
            OP_PASS: result = a;
            OP_MFHI: result = hi;
            OP_MFLO: result = lo;
            OP_BLTZ, OP_BGTZ, OP_BGEZ, OP_BNE, OP_BLEZ: result = a;
            default: result = 32'd0;
        endcase
    end

    // Branch condition evaluation; false for anything that is not a branch code
    always_comb begin
        cond = 1'b0;
        case (alucontrol)
            OP_BLTZ: cond = a[31];
            OP_BGTZ: cond = !a[31] && (a != 32'd0);
            OP_BGEZ: cond = !a[31];
            OP_BNE:  cond = (a != b);
            OP_BLEZ: cond = a[31] || (a == 32'd0);
            default: cond = 1'b0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: tb/tb_mips_cpu_alu_hilo.sv
// Self-checking bench for mips_cpu_alu_hilo.
// Stimulus pushes expected responses into queues; a monitor pops and compares them
// whenever a combinational check is strobed or the DUT pulses done.
module tb_mips_cpu_alu_hilo;

    localparam logic [4:0] OP_AND   = 5'b00000;
    localparam logic [4:0] OP_OR    = 5'b00001;
    localparam logic [4:0] OP_XOR   = 5'b00010;
    localparam logic [4:0] OP_ADDU  = 5'b00011;
    localparam logic [4:0] OP_SUBU  = 5'b00100;
    localparam logic [4:0] OP_SLTU  = 5'b00101;
    localparam logic [4:0] OP_SLT   = 5'b00110;
    localparam logic [4:0] OP_MULTU = 5'b00111;
    localparam logic [4:0] OP_MULT  = 5'b01000;
    localparam logic [4:0] OP_SLL   = 5'b01001;
    localparam logic [4:0] OP_SLLV  = 5'b01010;
    localparam logic [4:0] OP_SRA   = 5'b01011;
    localparam logic [4:0] OP_SRL   = 5'b01100;
    localparam logic [4:0] OP_SRAV  = 5'b01101;
    localparam logic [4:0] OP_SRLV  = 5'b01110;
    localparam logic [4:0] OP_DIV   = 5'b01111;
    localparam logic [4:0] OP_DIVU  = 5'b10000;
    localparam logic [4:0] OP_MTHI  = 5'b10001;
    localparam logic [4:0] OP_MTLO  = 5'b10010;
    localparam logic [4:0] OP_BLTZ  = 5'b10011;
    localparam logic [4:0] OP_BGTZ  = 5'b10100;
    localparam logic [4:0] OP_BGEZ  = 5'b10101;
    localparam logic [4:0] OP_BNE   = 5'b10110;
    localparam logic [4:0] OP_BLEZ  = 5'b10111;
    localparam logic [4:0] OP_PASS  = 5'b11000;
    localparam logic [4:0] OP_LUI   = 5'b11001;
    localparam logic [4:0] OP_MFHI  = 5'b11010;
    localparam logic [4:0] OP_MFLO  = 5'b11011;
    localparam logic [4:0] OP_UNDEF = 5'b11111;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        zero;
        logic        cond;
    } combExp_t;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } mdExp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  alucontrol;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        zero;
    logic        cond;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    combExp_t combQ[$];
    mdExp_t   mdQ[$];
    logic     combStrobe;
    int       assertCount;
    int       failCount;
    combExp_t monComb;
    mdExp_t   monMd;

    mips_cpu_alu_hilo dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .shamt      (shamt),
        .result     (result),
        .zero       (zero),
        .cond       (cond),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] code, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [4:0] sh);
        alucontrol = code;
        a          = av;
        b          = bv;
        shamt      = sh;
    endtask

    // Drive one combinational operation and queue its expected result for the monitor
    task automatic runComb(input string name, input logic [4:0] code, input logic [31:0] av,
                           input logic [31:0] bv, input logic [4:0] sh,
                           input logic [31:0] expRes, input logic expCond);
        @(posedge clk);
        #1;
        applyStimulus(code, av, bv, sh);
        combQ.push_back('{name, expRes, (expRes == 32'd0), expCond});
        combStrobe = 1'b1;
        @(negedge clk);
        #1;
        combStrobe = 1'b0;
    endtask

    // Launch a mul/div, measure busy and done timing; HI/LO are checked by the monitor on done
    task automatic runMulDiv(input string name, input logic [4:0] code, input logic [31:0] av,
                             input logic [31:0] bv, input logic [31:0] expHi, input logic [31:0] expLo,
                             input bit stray, input logic [31:0] oldHi);
        int busyCycles;
        bit seen;
        @(posedge clk);
        #1;
        applyStimulus(code, av, bv, 5'd0);
        mdQ.push_back('{name, expHi, expLo});
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busyCycles = 0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (busy) busyCycles++;
            if (done) seen = 1;
            if (stray && i == 6) begin
                #1;
                combStrobe = 1'b0;
            end
            if (stray && i == 5) begin
                applyStimulus(OP_MTHI, 32'h12345678, 32'd0, 5'd0);
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                checkOutput({name, " stray mthi ignored"}, {32'd0, hi}, {32'd0, oldHi});
                applyStimulus(OP_MFHI, 32'd0, 32'd0, 5'd0);
                combQ.push_back('{{name, " mfhi while busy"}, oldHi, (oldHi == 32'd0), 1'b0});
                combStrobe = 1'b1;
            end
        end
        if (!seen) checkOutput({name, " done timeout"}, 64'd0, 64'd1);
        checkOutput({name, " busy cycles"}, 64'(busyCycles), 64'd33);
        @(negedge clk);
        checkOutput({name, " done width"}, {63'd0, done}, 64'd0);
        checkOutput({name, " busy after done"}, {63'd0, busy}, 64'd0);
    endtask

    // Scoreboard monitor: compares queued expectations when the bench strobes or the DUT signals done
    always @(negedge clk) begin
        if (combStrobe) begin
            if (combQ.size() == 0) begin
                checkOutput("comb queue underflow", 64'd1, 64'd0);
            end else begin
                monComb = combQ.pop_front();
                checkOutput({monComb.name, " result"}, {32'd0, result}, {32'd0, monComb.res});
                checkOutput({monComb.name, " zero"}, {63'd0, zero}, {63'd0, monComb.zero});
                checkOutput({monComb.name, " cond"}, {63'd0, cond}, {63'd0, monComb.cond});
            end
        end
        if (done === 1'b1) begin
            if (mdQ.size() == 0) begin
                checkOutput("unexpected done", 64'd1, 64'd0);
            end else begin
                monMd = mdQ.pop_front();
                checkOutput({monMd.name, " hi"}, {32'd0, hi}, {32'd0, monMd.hi});
                checkOutput({monMd.name, " lo"}, {32'd0, lo}, {32'd0, monMd.lo});
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence
    initial begin
        assertCount = 0;
        failCount   = 0;
        combStrobe  = 1'b0;
        reset       = 1'b0;
        start       = 1'b0;
        applyStimulus(OP_AND, 32'd0, 32'd0, 5'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", {63'd0, busy}, 64'd0);
        checkOutput("reset done", {63'd0, done}, 64'd0);
        checkOutput("reset hi", {32'd0, hi}, 64'd0);
        checkOutput("reset lo", {32'd0, lo}, 64'd0);
        reset = 1'b1;

        $display("[TB] combinational operations");
        runComb("mfhi after reset", OP_MFHI, 32'd7, 32'd7, 5'd0, 32'd0, 1'b0);
        runComb("mflo after reset", OP_MFLO, 32'd7, 32'd7, 5'd0, 32'd0, 1'b0);
        runComb("and",  OP_AND,  32'hF0F000FF, 32'h0FF00F0F, 5'd0, 32'h00F0000F, 1'b0);
        runComb("or",   OP_OR,   32'hF0F000FF, 32'h0FF00F0F, 5'd0, 32'hFFF00FFF, 1'b0);
        runComb("xor",  OP_XOR,  32'hF0F000FF, 32'h0FF00F0F, 5'd0, 32'hFF000FF0, 1'b0);
        runComb("addu wrap", OP_ADDU, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1'b0);
        runComb("subu", OP_SUBU, 32'd5, 32'd7, 5'd0, 32'hFFFFFFFE, 1'b0);
        runComb("slt",  OP_SLT,  32'hFFFFFFFF, 32'd1, 5'd0, 32'd1, 1'b0);
        runComb("sltu", OP_SLTU, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, 1'b0);
        runComb("sll",  OP_SLL,  32'd0, 32'd1, 5'd31, 32'h80000000, 1'b0);
        runComb("srl",  OP_SRL,  32'd0, 32'h80000000, 5'd31, 32'h00000001, 1'b0);
        runComb("sra",  OP_SRA,  32'd0, 32'h80000000, 5'd4, 32'hF8000000, 1'b0);
        runComb("sllv", OP_SLLV, 32'd33, 32'd3, 5'd0, 32'd6, 1'b0);
        runComb("srlv", OP_SRLV, 32'd36, 32'h80000000, 5'd0, 32'h08000000, 1'b0);
        runComb("srav", OP_SRAV, 32'd4, 32'h80000000, 5'd9, 32'hF8000000, 1'b0);
        runComb("lui",  OP_LUI,  32'd0, 32'h00001234, 5'd0, 32'h12340000, 1'b0);
        runComb("pass", OP_PASS, 32'h12345678, 32'd1, 5'd0, 32'h12345678, 1'b0);
        runComb("bgez a=0", OP_BGEZ, 32'd0, 32'd0, 5'd0, 32'd0, 1'b1);
        runComb("bgtz a=0", OP_BGTZ, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0);
        runComb("bgtz a=1", OP_BGTZ, 32'd1, 32'd0, 5'd0, 32'd1, 1'b1);
        runComb("bne equal", OP_BNE, 32'd5, 32'd5, 5'd0, 32'd5, 1'b0);
        runComb("bne differ", OP_BNE, 32'd5, 32'd6, 5'd0, 32'd5, 1'b1);
        runComb("bltz neg", OP_BLTZ, 32'h80000000, 32'd0, 5'd0, 32'h80000000, 1'b1);
        runComb("blez a=0", OP_BLEZ, 32'd0, 32'd0, 5'd0, 32'd0, 1'b1);
        runComb("addu cond", OP_ADDU, 32'd1, 32'd2, 5'd0, 32'd3, 1'b0);
        runComb("mult code result", OP_MULT, 32'd3, 32'd4, 5'd0, 32'd0, 1'b0);
        runComb("undefined code", OP_UNDEF, 32'd5, 32'd5, 5'd0, 32'd0, 1'b0);

        $display("[TB] multiply and divide");
        runMulDiv("mult -3*5", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 32'd0);
        runMulDiv("multu max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 32'd0);
        runMulDiv("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 32'd0);
        runMulDiv("divu 7/0", OP_DIVU, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 32'd0);
        runMulDiv("div min/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 32'd0);
        runMulDiv("mult 7*-6", OP_MULT, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 0, 32'd0);
        runMulDiv("div 7/-2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 32'd0);
        runMulDiv("divu 100/7 stray", OP_DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1, 32'h00000001);

        $display("[TB] reset during divide");
        @(posedge clk);
        #1;
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 5'd0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        checkOutput("abort busy", {63'd0, busy}, 64'd0);
        checkOutput("abort done", {63'd0, done}, 64'd0);
        checkOutput("abort hi", {32'd0, hi}, 64'd0);
        checkOutput("abort lo", {32'd0, lo}, 64'd0);
        repeat (40) @(negedge clk);

        $display("[TB] undefined start and move-to");
        @(posedge clk);
        #1;
        applyStimulus(OP_UNDEF, 32'd5, 32'd5, 5'd0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("undefined start busy", {63'd0, busy}, 64'd0);
        checkOutput("undefined start hi", {32'd0, hi}, 64'd0);

        @(posedge clk);
        #1;
        applyStimulus(OP_MTHI, 32'hDEADBEEF, 32'd0, 5'd0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("mthi busy", {63'd0, busy}, 64'd0);
        runComb("mfhi after mthi", OP_MFHI, 32'd0, 32'd0, 5'd0, 32'hDEADBEEF, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(OP_MTLO, 32'hCAFEF00D, 32'd0, 5'd0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        runComb("mflo after mtlo", OP_MFLO, 32'd0, 32'd0, 5'd0, 32'hCAFEF00D, 1'b0);
        runComb("mfhi kept", OP_MFHI, 32'd0, 32'd0, 5'd0, 32'hDEADBEEF, 1'b0);

        repeat (2) @(negedge clk);
        checkOutput("mul/div queue drained", 64'(mdQ.size()), 64'd0);
        checkOutput("comb queue drained", 64'(combQ.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
